// File: rtl/jtag_tap_dtm_if.sv
// rtl/jtag_tap_dtm_if.sv - DMI request/response bus between the DTM and the debug module.
interface jtag_tap_dtm_if #(
  parameter int DMI_ABITS = 6
);
  logic                 dmi_req_valid;
  logic                 dmi_req_ready;
  logic [DMI_ABITS-1:0] dmi_req_addr;
  logic [31:0]          dmi_req_data;
  logic [1:0]           dmi_req_op;
  logic                 dmi_resp_valid;
  logic                 dmi_resp_ready;
  logic [31:0]          dmi_resp_data;
  logic [1:0]           dmi_resp_op;

  modport master (
    output dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_resp_ready,
    input  dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_op
  );

  modport slave (
    input  dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_resp_ready,
    output dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_op
  );
endinterface

// File: rtl/jtag_tap_dtm.sv
// rtl/jtag_tap_dtm.sv - JTAG TAP and debug transport module, pins oversampled in the clk domain.
module jtag_tap_dtm #(
  parameter logic [31:0] IDCODE    = 32'h1E200A6D,
  parameter int          DMI_ABITS = 6,
  parameter int          IDLE_HINT = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jtag_TCK,
  input  logic                  jtag_TMS,
  input  logic                  jtag_TDI,
  output logic                  jtag_TDO,
  output logic [3:0]            tap_state,
  jtag_tap_dtm_if.master        dmi
);
  localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SEL_DR = 4'd2, CAP_DR = 4'd3,
                         SH_DR = 4'd4, EX1_DR = 4'd5, PAUSE_DR = 4'd6, EX2_DR = 4'd7,
                         UPD_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11,
                         EX1_IR = 4'd12, PAUSE_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15;
  localparam logic [4:0] IR_IDCODE = 5'h01, IR_DTMCS = 5'h10, IR_DMI = 5'h11;
  localparam int DRW = DMI_ABITS + 34;
  localparam int DLW = $clog2(DRW);

  logic [2:0]           tck_s;
  logic [1:0]           tms_s, tdi_s;
  logic                 tck_rise, tck_fall, tms, tdi;
  logic [3:0]           state, state_nxt;
  logic [4:0]           ir, ir_shift;
  logic [DRW-1:0]       dr_shift, dr_shifted, dr_cap;
  logic [DLW-1:0]       dr_msb;
  logic [1:0]           dmistat, dmi_status;
  logic [DMI_ABITS-1:0] last_addr;
  logic [31:0]          resp_data_reg, dtmcs_cap;
  logic                 outstanding;
  logic [1:0]           upd_op;

  assign tck_rise  = tck_s[1] & ~tck_s[2];
  assign tck_fall  = ~tck_s[1] & tck_s[2];
  assign tms       = tms_s[1];
  assign tdi       = tdi_s[1];
  assign tap_state = state;
  assign outstanding = dmi.dmi_req_valid | dmi.dmi_resp_ready;
  assign upd_op    = dr_shift[1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:      state_nxt = tms ? TLR    : RTI;
      RTI:      state_nxt = tms ? SEL_DR : RTI;
      SEL_DR:   state_nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:   state_nxt = tms ? EX1_DR : SH_DR;
      SH_DR:    state_nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:   state_nxt = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_nxt = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:   state_nxt = tms ? SEL_DR : RTI;
      SEL_IR:   state_nxt = tms ? TLR    : CAP_IR;
      CAP_IR:   state_nxt = tms ? EX1_IR : SH_IR;
      SH_IR:    state_nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:   state_nxt = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_nxt = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:   state_nxt = tms ? SEL_DR : RTI;
    endcase
  end

  // TDI enters at the top of the selected register's length, so short registers keep zeros above.
  always_comb begin
    case (ir)
      IR_IDCODE, IR_DTMCS: dr_msb = DLW'(31);
      IR_DMI:              dr_msb = DLW'(DRW - 1);
      default:             dr_msb = '0;
    endcase
    dr_shifted         = dr_shift >> 1;
    dr_shifted[dr_msb] = tdi;
  end

  always_comb begin
    dmi_status = (dmistat != 2'd0) ? dmistat : (outstanding ? 2'd3 : 2'd0);
    dtmcs_cap  = {17'b0, 3'(IDLE_HINT), dmistat, 6'(DMI_ABITS), 4'd1};
    case (ir)
      IR_IDCODE: dr_cap = DRW'(IDCODE);
      IR_DTMCS:  dr_cap = DRW'(dtmcs_cap);
      IR_DMI:    dr_cap = {last_addr, resp_data_reg, dmi_status};
      default:   dr_cap = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tck_s              <= '0;
      tms_s              <= '0;
      tdi_s              <= '0;
      state              <= TLR;
      ir                 <= IR_IDCODE;
      ir_shift           <= '0;
      dr_shift           <= '0;
      jtag_TDO           <= 1'b0;
      dmistat            <= '0;
      last_addr          <= '0;
      resp_data_reg      <= '0;
      dmi.dmi_req_valid  <= 1'b0;
      dmi.dmi_req_addr   <= '0;
      dmi.dmi_req_data   <= '0;
      dmi.dmi_req_op     <= '0;
      dmi.dmi_resp_ready <= 1'b0;
    end else begin
      tck_s <= {tck_s[1:0], jtag_TCK};
      tms_s <= {tms_s[0], jtag_TMS};
      tdi_s <= {tdi_s[0], jtag_TDI};

      if (tck_rise) begin
        state <= state_nxt;
        case (state)
          CAP_IR:  ir_shift <= 5'b00001;
          SH_IR:   ir_shift <= {tdi, ir_shift[4:1]};
          CAP_DR:  dr_shift <= dr_cap;
          SH_DR:   dr_shift <= dr_shifted;
          default: ;
        endcase
        if (state_nxt == UPD_IR) ir <= ir_shift;
      end
      if (state == TLR) ir <= IR_IDCODE;

      if (tck_fall) begin
        if (state == SH_IR)      jtag_TDO <= ir_shift[0];
        else if (state == SH_DR) jtag_TDO <= dr_shift[0];
        else                     jtag_TDO <= 1'b0;
      end

      if (dmi.dmi_req_valid && dmi.dmi_req_ready) begin
        dmi.dmi_req_valid  <= 1'b0;
        dmi.dmi_resp_ready <= 1'b1;
      end
      if (dmi.dmi_resp_ready && dmi.dmi_resp_valid) begin
        dmi.dmi_resp_ready <= 1'b0;
        resp_data_reg      <= dmi.dmi_resp_data;
        if (dmi.dmi_resp_op == 2'd2) dmistat <= 2'd2;
      end

      // Update actions fire on the rise that enters UpdDR; they override handshake bookkeeping.
      if (tck_rise && state_nxt == UPD_DR) begin
        case (ir)
          IR_DTMCS: begin
            if (dr_shift[17]) begin
              dmi.dmi_req_valid  <= 1'b0;
              dmi.dmi_resp_ready <= 1'b0;
              dmistat            <= 2'd0;
            end else if (dr_shift[16]) begin
              dmistat <= 2'd0;
            end
          end
          IR_DMI: begin
            if (upd_op == 2'd1 || upd_op == 2'd2) begin
              if (outstanding) begin
                dmistat <= 2'd3;
              end else if (dmistat == 2'd0) begin
                last_addr         <= dr_shift[DRW-1:34];
                dmi.dmi_req_addr  <= dr_shift[DRW-1:34];
                dmi.dmi_req_data  <= dr_shift[33:2];
                dmi.dmi_req_op    <= upd_op;
                dmi.dmi_req_valid <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jtag_tap_dtm.sv
// tb/tb_jtag_tap_dtm.sv - Scoreboarded bench for jtag_tap_dtm: TAP scans plus a DMI responder.
module tb_jtag_tap_dtm;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       jtag_TCK = 1'b0, jtag_TMS = 1'b0, jtag_TDI = 1'b0;
  logic       jtag_TDO;
  logic [3:0] tap_state;
  logic       ready_en = 1'b0;
  logic [31:0] resp_word = 32'h0;
  logic [1:0]  resp_op_v = 2'd0;
  int n_checks = 0;
  int n_fail = 0;

  logic [39:0] cap_q[$];
  logic [39:0] req_q[$];

  jtag_tap_dtm_if #(.DMI_ABITS(6)) dmi_bus ();

  jtag_tap_dtm dut (
    .clk(clk), .rst(rst),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO),
    .tap_state(tap_state), .dmi(dmi_bus.master)
  );

  always #10 clk = ~clk;
  assign dmi_bus.dmi_req_ready = ready_en;

  // Responder answers whenever the DTM is ready; the monitor retires expected requests at handshake.
  always @(negedge clk) begin
    logic [39:0] exp_req;
    if (!rst) begin
      dmi_bus.dmi_resp_valid = 1'b0;
      dmi_bus.dmi_resp_data  = 32'h0;
      dmi_bus.dmi_resp_op    = 2'd0;
    end else begin
      dmi_bus.dmi_resp_valid = dmi_bus.dmi_resp_ready;
      dmi_bus.dmi_resp_data  = resp_word;
      dmi_bus.dmi_resp_op    = resp_op_v;
      if (dmi_bus.dmi_req_valid && ready_en) begin
        n_checks++;
        if (req_q.size() == 0) begin
          n_fail++;
          $display("FAIL req_unexpected: got %h, expected no request",
                   {dmi_bus.dmi_req_addr, dmi_bus.dmi_req_data, dmi_bus.dmi_req_op});
        end else begin
          exp_req = req_q.pop_front();
          if ({dmi_bus.dmi_req_addr, dmi_bus.dmi_req_data, dmi_bus.dmi_req_op} !== exp_req) begin
            n_fail++;
            $display("FAIL req_fields: got %h, expected %h",
                     {dmi_bus.dmi_req_addr, dmi_bus.dmi_req_data, dmi_bus.dmi_req_op}, exp_req);
          end
        end
      end
    end
  end

  task automatic tck(input logic tms_v, input logic tdi_v, output logic tdo_v);
    jtag_TMS = tms_v;
    jtag_TDI = tdi_v;
    @(negedge clk);
    tdo_v = jtag_TDO;
    jtag_TCK = 1'b1;
    repeat (5) @(negedge clk);
    jtag_TCK = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic goto_rti();
    logic b;
    for (int i = 0; i < 8; i++) tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
  endtask

  task automatic scan_ir(input logic [4:0] val);
    logic b;
    tck(1'b1, 1'b0, b);
    tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
    tck(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) tck(i == 4, val[i], b);
    tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
  endtask

  task automatic scan_dr(input logic [39:0] din, input int len, input string name);
    logic        b;
    logic [39:0] dout, exp_v;
    dout = '0;
    tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
    tck(1'b0, 1'b0, b);
    for (int i = 0; i < len; i++) begin
      tck(i == len - 1, din[i], b);
      dout[i] = b;
    end
    tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
    exp_v = cap_q.pop_front();
    n_checks++;
    if (dout !== exp_v) begin
      n_fail++;
      $display("FAIL %s: shifted out %h, expected %h", name, dout, exp_v);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((dmi_bus.dmi_req_valid || dmi_bus.dmi_resp_ready) && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL %s: DMI transaction still pending after %0d cycles, expected idle", name, k);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks += 4;
    if (tap_state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", tap_state); end
    if (jtag_TDO !== 1'b0) begin n_fail++; $display("FAIL reset_tdo: got %b, expected 0", jtag_TDO); end
    if (dmi_bus.dmi_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b, expected 0", dmi_bus.dmi_req_valid); end
    if (dmi_bus.dmi_resp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_resp_ready: got %b, expected 0", dmi_bus.dmi_resp_ready); end
  endtask

  task automatic test_idcode();
    logic b;
    for (int i = 0; i < 8; i++) tck(1'b1, 1'b0, b);
    n_checks++;
    if (tap_state !== 4'd0) begin n_fail++; $display("FAIL tlr_state: got %0d, expected 0", tap_state); end
    tck(1'b0, 1'b0, b);
    n_checks++;
    if (tap_state !== 4'd1) begin n_fail++; $display("FAIL rti_state: got %0d, expected 1", tap_state); end
    cap_q.push_back(40'h00_1E200A6D);
    scan_dr(40'h0, 32, "idcode");
  endtask

  task automatic test_dtmcs();
    scan_ir(5'h10);
    cap_q.push_back(40'h00_00005061);
    scan_dr(40'h0, 32, "dtmcs");
  endtask

  task automatic test_dmi_write();
    ready_en  = 1'b0;
    resp_word = 32'h0;
    scan_ir(5'h11);
    cap_q.push_back(40'h0);
    req_q.push_back({6'h10, 32'h0, 2'b10});
    scan_dr({6'h10, 32'h0, 2'b10}, 40, "dmi_write_cap");
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({dmi_bus.dmi_req_valid, dmi_bus.dmi_req_addr, dmi_bus.dmi_req_data, dmi_bus.dmi_req_op}
          !== {1'b1, 6'h10, 32'h0, 2'd2}) begin
        n_fail++;
        $display("FAIL write_stall_%0d: got v=%b a=%h d=%h op=%0d, expected v=1 a=10 d=0 op=2", c,
                 dmi_bus.dmi_req_valid, dmi_bus.dmi_req_addr, dmi_bus.dmi_req_data, dmi_bus.dmi_req_op);
      end
      @(negedge clk);
    end
    ready_en = 1'b1;
    wait_idle("write_complete");
  endtask

  task automatic test_dmi_read();
    resp_word = 32'hDEADBEEF;
    req_q.push_back({6'h11, 32'h0, 2'b01});
    cap_q.push_back({6'h10, 32'h0, 2'b00});
    scan_dr({6'h11, 32'h0, 2'b01}, 40, "dmi_read_issue");
    wait_idle("read_complete");
    cap_q.push_back({6'h11, 32'hDEADBEEF, 2'b00});
    scan_dr(40'h0, 40, "dmi_read_data");
  endtask

  task automatic test_busy();
    ready_en = 1'b0;
    req_q.push_back({6'h12, 32'h12345678, 2'b10});
    cap_q.push_back({6'h11, 32'hDEADBEEF, 2'b00});
    scan_dr({6'h12, 32'h12345678, 2'b10}, 40, "busy_first");
    cap_q.push_back({6'h12, 32'hDEADBEEF, 2'b11});
    scan_dr({6'h13, 32'h0000AAAA, 2'b10}, 40, "busy_second");
    n_checks++;
    if (dmi_bus.dmi_req_addr !== 6'h12) begin
      n_fail++;
      $display("FAIL busy_hold_addr: got %h, expected 12", dmi_bus.dmi_req_addr);
    end
    resp_word = 32'hCAFE0001;
    ready_en  = 1'b1;
    wait_idle("busy_complete");
    repeat (20) @(negedge clk);
    cap_q.push_back({6'h12, 32'hCAFE0001, 2'b11});
    scan_dr(40'h0, 40, "busy_sticky");
    scan_ir(5'h10);
    cap_q.push_back(40'h00_00005C61);
    scan_dr(40'h00_00010000, 32, "dtmcs_dmireset");
    scan_ir(5'h11);
    cap_q.push_back({6'h12, 32'hCAFE0001, 2'b00});
    scan_dr(40'h0, 40, "after_dmireset");
  endtask

  task automatic test_reset_mid();
    logic b;
    ready_en = 1'b0;
    cap_q.push_back({6'h12, 32'hCAFE0001, 2'b00});
    scan_dr({6'h15, 32'h00000055, 2'b10}, 40, "pre_reset_issue");
    tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
    tck(1'b0, 1'b0, b);
    for (int i = 0; i < 3; i++) tck(1'b0, 1'b1, b);
    rst = 1'b0;
    @(negedge clk);
    n_checks += 4;
    if (jtag_TDO !== 1'b0) begin n_fail++; $display("FAIL midrst_tdo: got %b, expected 0", jtag_TDO); end
    if (tap_state !== 4'd0) begin n_fail++; $display("FAIL midrst_state: got %0d, expected 0", tap_state); end
    if (dmi_bus.dmi_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_req_valid: got %b, expected 0", dmi_bus.dmi_req_valid); end
    if (dmi_bus.dmi_resp_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_resp_ready: got %b, expected 0", dmi_bus.dmi_resp_ready); end
    rst = 1'b1;
    ready_en = 1'b1;
    repeat (3) @(negedge clk);
    tck(1'b0, 1'b0, b);
    cap_q.push_back(40'h00_1E200A6D);
    scan_dr(40'h0, 32, "idcode_after_reset");
    n_checks++;
    if (req_q.size() != 0) begin
      n_fail++;
      $display("FAIL req_leftover: %0d requests never seen, expected 0", req_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_dtmcs();
    test_dmi_write();
    test_dmi_read();
    test_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
